// File: rtl/valu_sequencer.sv
// Sequencer for the 512-bit vector ALU: one command in flight, reads two source
// vectors, strobes add/mul for EXEC_LAT cycles, then writes back lo (and hi for mul).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a command, ALU held in reset
// S_READ  | register-file read of both sources, operands captured
// S_EXEC  | add/mul strobe held while the latency counter runs down
// S_WB_LO | write low half of the result to dst
// S_WB_HI | mul only: write high half to dst+1 (wraps)
// S_ERR   | reserved opcode, one-cycle err pulse
module valu_sequencer #(
   parameter int DATA_W   = 512,
   parameter int REG_AW   = 2,
   parameter int EXEC_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [REG_AW-1:0] cmd_src1,
   input  logic [REG_AW-1:0] cmd_src2,
   input  logic [REG_AW-1:0] cmd_dst,
   output logic [REG_AW-1:0] rf_rd_addr1,
   output logic [REG_AW-1:0] rf_rd_addr2,
   input  logic [DATA_W-1:0] rf_rd_data1,
   input  logic [DATA_W-1:0] rf_rd_data2,
   output logic [DATA_W-1:0] alu_a1,
   output logic [DATA_W-1:0] alu_a2,
   output logic              alu_add,
   output logic              alu_mul,
   output logic              alu_reset,
   input  logic [DATA_W-1:0] alu_lo,
   input  logic [DATA_W-1:0] alu_hi,
   output logic              rf_wr_en,
   output logic [REG_AW-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       op_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_EXEC, S_WB_LO, S_WB_HI, S_ERR
   } state_t;

   localparam logic [3:0]        LAT    = 4'(EXEC_LAT);
   localparam logic [REG_AW-1:0] ADDR_1 = REG_AW'(1);

   state_t              state_q, state_d;
   logic                mul_q, mul_d;
   logic [REG_AW-1:0]   src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   a1_q, a1_d, a2_q, a2_d, lo_q, lo_d, hi_q, hi_d;
   logic [15:0]         op_count_q, op_count_d;
   logic                wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         mul_q      <= 1'b0;
         src1_q     <= '0;
         src2_q     <= '0;
         dst_q      <= '0;
         cnt_q      <= '0;
         a1_q       <= '0;
         a2_q       <= '0;
         lo_q       <= '0;
         hi_q       <= '0;
         op_count_q <= '0;
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mul_q      <= mul_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         dst_q      <= dst_d;
         cnt_q      <= cnt_d;
         a1_q       <= a1_d;
         a2_q       <= a2_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         op_count_q <= op_count_d;
         wr_en_q    <= wr_en_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mul_d      = mul_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      dst_d      = dst_q;
      cnt_d      = cnt_q;
      a1_d       = a1_q;
      a2_d       = a2_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      op_count_d = op_count_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               mul_d   = cmd_op[0];
               src1_d  = cmd_src1;
               src2_d  = cmd_src2;
               dst_d   = cmd_dst;
               state_d = cmd_op[1] ? S_ERR : S_READ;
            end
         end
         S_READ: begin
            a1_d    = rf_rd_data1;
            a2_d    = rf_rd_data2;
            cnt_d   = LAT;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               lo_d    = alu_lo;
               hi_d    = alu_hi;
               state_d = S_WB_LO;
            end
         end
         S_WB_LO: begin
            if (mul_q) begin
               state_d = S_WB_HI;
            end else begin
               op_count_d = op_count_q + 16'd1;
               state_d    = S_IDLE;
            end
         end
         S_WB_HI: begin
            op_count_d = op_count_q + 16'd1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Pulse outputs are registered against the state being entered.
      wr_en_d = (state_d == S_WB_LO) || (state_d == S_WB_HI);
      done_d  = ((state_d == S_WB_LO) && !mul_d) || (state_d == S_WB_HI);
      err_d   = (state_d == S_ERR);
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign alu_reset   = (state_q == S_IDLE);
   assign alu_add     = (state_q == S_EXEC) && !mul_q;
   assign alu_mul     = (state_q == S_EXEC) && mul_q;
   assign rf_rd_addr1 = src1_q;
   assign rf_rd_addr2 = src2_q;
   assign alu_a1      = a1_q;
   assign alu_a2      = a2_q;
   assign rf_wr_en    = wr_en_q;
   assign rf_wr_addr  = (state_q == S_WB_HI) ? dst_q + ADDR_1 : dst_q;
   assign rf_wr_data  = (state_q == S_WB_HI) ? hi_q : lo_q;
   assign done        = done_q;
   assign err         = err_q;
   assign op_count    = op_count_q;

endmodule

// File: doc/valu_sequencer.md
Name: valu_sequencer

Overview:
- Multi-cycle controller that sequences the 512-bit vector ALU (add/mul, 1024-bit result split low/high).
- Accepts one command at a time over a valid/ready handshake, reads two source vectors from the vector register file, and drives the ALU operands and operation strobes.
- Captures the ALU result and writes it back to the register file.
- Sits between the instruction decode stage and the ALU/register-file pair.

Parameters:
- DATA_W, 512, vector width; ALU result is 2*DATA_W.
- REG_AW, 2, register-file address width (4 vector registers).
- EXEC_LAT, 2, cycles operands and strobe are held before result capture; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  operation: 00 add, 01 mul, 1x reserved.
- cmd_src1  in  REG_AW  first operand register.
- cmd_src2  in  REG_AW  second operand register.
- cmd_dst  in  REG_AW  destination register.
- rf_rd_addr1  out  REG_AW  register-file read address 1.
- rf_rd_addr2  out  REG_AW  register-file read address 2.
- rf_rd_data1  in  DATA_W  read data 1; combinational from address.
- rf_rd_data2  in  DATA_W  read data 2; combinational from address.
- alu_a1  out  DATA_W  ALU operand 1, registered.
- alu_a2  out  DATA_W  ALU operand 2, registered.
- alu_add  out  1  ALU add strobe.
- alu_mul  out  1  ALU mul strobe.
- alu_reset  out  1  active-high ALU clear.
- alu_lo  in  DATA_W  ALU result bits [DATA_W-1:0].
- alu_hi  in  DATA_W  ALU result bits [2*DATA_W-1:DATA_W].
- rf_wr_en  out  1  register-file write enable.
- rf_wr_addr  out  REG_AW  write address.
- rf_wr_data  out  DATA_W  write data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse on the final write of a command.
- err  out  1  one-cycle pulse on a reserved opcode.
- op_count  out  16  number of completed valid commands.

Behaviour:
- Reset (reset low, async): state=IDLE; every registered output is 0, including alu_a1/a2, op_count, done, err and rf_wr_en. cmd_ready=1 and alu_reset=1 are decoded from IDLE. Reset mid-command aborts it with no further register-file write.
- States: IDLE, READ, EXEC, WB_LO, WB_HI, ERR.
- IDLE:
  - cmd_ready=1 and alu_reset=1; strobes are 0.
  - On cmd_valid&&cmd_ready, latch op/src1/src2/dst.
  - Next state is READ for op 00/01, ERR for op 1x.
- READ:
  - rf_rd_addr1/2 = latched src1/src2.
  - At the clock edge, alu_a1/alu_a2 capture rf_rd_data1/2.
  - Load the exec counter with EXEC_LAT; next state EXEC.
- EXEC:
  - alu_add=1 for add, alu_mul=1 for mul; never both. alu_reset=0.
  - Counter decrements each cycle. On the cycle where counter==1, capture alu_lo/alu_hi into result registers; next state WB_LO.
- WB_LO:
  - rf_wr_en=1, rf_wr_addr=dst, rf_wr_data=captured lo.
  - Add: done=1 this cycle, op_count+1, next state IDLE.
  - Mul: next state WB_HI.
- WB_HI (mul only):
  - rf_wr_en=1, rf_wr_addr=(dst+1) mod 2^REG_AW (wraps 3->0), rf_wr_data=captured hi.
  - done=1, op_count+1, next state IDLE.
- Add carry (alu_hi bit 0) is discarded; add never writes a second register.
- ERR: err=1 for one cycle, no write, no op_count change, next state IDLE.
- Latency, command accepted at edge T:
  - READ in cycle T+1; EXEC in T+2..T+1+EXEC_LAT.
  - lo write in T+2+EXEC_LAT; hi write in T+3+EXEC_LAT.
  - cmd_ready returns the cycle after the final write, giving one command in flight.
- cmd_valid while busy is ignored; the command must be held by the source until accepted.
- src1, src2 and dst may alias. Operands are latched in READ, so writeback never corrupts the operands in use. A mul with dst=src overwrites src, then src+1.
- op_count wraps 0xFFFF->0x0000.
- Registered outputs alu_a1/a2 hold their value after completion; they are not cleared on return to IDLE.

Test Plan:
- Reset asserted mid-EXEC of a mul -> next cycle: IDLE, cmd_ready=1, rf_wr_en=0, op_count unchanged, alu_reset=1, no writes afterward.
- Add: R0=5, R1=7, op=00 src1=0 src2=1 dst=2, EXEC_LAT=2 -> alu_add high in T+2..T+3; write R2=12 at T+4 with done=1; cmd_ready=1 at T+5; op_count=1.
- Mul with high half: R0=2^511, R1=4, dst=3 -> R3 lo=0 written at T+4; R0 hi=2 written at T+5 (dst wraps to 0); done only at T+5.
- Back-to-back: cmd_valid held high with two adds -> second accepted at T+5 (not earlier); both results correct; op_count=2.
- Reserved op 10 -> err pulse 1 cycle at T+1, no rf_wr_en, op_count unchanged, cmd_ready=1 at T+2.
- Aliasing: R1=3, add src1=1 src2=1 dst=1 -> R1=6; op_count preset to 0xFFFF wraps to 0x0000.
